// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC default
// and instruction field positions.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } fetch_state_t;

   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int JUMP_MSB   = 25;
   localparam int JUMP_LSB   = 0;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;

   function automatic logic [5:0] opcodeOf(input logic [31:0] word);
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_imem_wait_timer.sv
// Loadable wait counter with clear and enable; expired is high once LIMIT counted cycles
// have elapsed. Shared by the instruction and data memory interfaces.
module imem_wait_timer #(
   parameter int LIMIT = 15,
   parameter int CW    = $clog2(LIMIT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   input  logic          load,
   input  logic [CW-1:0] loadValue,
   output logic          expired
);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

   // Saturates at LIMIT-1 so the LIMIT-th enabled cycle is the one flagged.
   assign expired = (count >= CW'(LIMIT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over imem req/ack, holds the instruction
// for next-address logic. Optional IF_ALIGN_CHECK_EN faults on a misaligned new_pc.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
   parameter int              MAX_WAIT = 15
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic            new_pc_valid,
   input  logic [31:0]     new_pc,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [PC_W-1:0] old_pc,
   output logic [25:0]     jump_offset,
   output logic [15:0]     branch_offset,
   output logic            fetch_fault,
   output logic [1:0]      dbgState
);

   fetch_state_t    state, nextState;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] loadPcValue;
   logic            issueFetch, latchInstr, timeout, acceptPc, alignFault;
   logic            timerClr, timerEn, timerExpired;
   logic            unusedNewPcBits;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         S_FETCH: nextState = S_WAIT;
         S_WAIT: begin
            if (imem_ack) begin
               nextState = S_HOLD;
            end else if (timerExpired) begin
               nextState = S_FAULT;
            end
         end
         S_HOLD: begin
            if (new_pc_valid && !stall) begin
`ifdef IF_ALIGN_CHECK_EN
               nextState = (new_pc[1:0] != 2'b00) ? S_FAULT : S_FETCH;
`else
               nextState = S_FETCH;
`endif
            end
         end
         default: nextState = state;
      endcase
   end

   // Output / control decode
   always_comb begin
      issueFetch = 1'b0;
      latchInstr = 1'b0;
      timeout    = 1'b0;
      acceptPc   = 1'b0;
      alignFault = 1'b0;
      timerEn    = 1'b0;
      timerClr   = 1'b1;
      case (state)
         S_FETCH: issueFetch = 1'b1;
         S_WAIT: begin
            latchInstr = imem_ack;
            timeout    = !imem_ack && timerExpired;
            timerEn    = !imem_ack;
            timerClr   = imem_ack;
         end
         S_HOLD: begin
            if (new_pc_valid && !stall) begin
`ifdef IF_ALIGN_CHECK_EN
               if (new_pc[1:0] != 2'b00) begin
                  alignFault = 1'b1;
               end else begin
                  acceptPc = 1'b1;
               end
`else
               acceptPc = 1'b1;
`endif
            end
         end
         default: ;
      endcase
   end

   // Fetches are always word aligned; upper new_pc bits beyond PC_W are dropped.
   assign loadPcValue     = {new_pc[PC_W-1:2], 2'b00};
   assign unusedNewPcBits = ^{new_pc[31:PC_W], new_pc[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instr       <= 32'h0;
         old_pc      <= RESET_PC;
         fetch_fault <= 1'b0;
      end else begin
         if (issueFetch) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
         end
         if (latchInstr) begin
            instr       <= imem_rdata;
            old_pc      <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
         end
         if (timeout) begin
            fetch_fault <= 1'b1;
            imem_req    <= 1'b0;
         end
         if (acceptPc) begin
            pc          <= loadPcValue;
            instr_valid <= 1'b0;
         end
         if (alignFault) begin
            fetch_fault <= 1'b1;
         end
      end
   end

   imem_wait_timer #(
      .LIMIT(MAX_WAIT)
   ) uWaitTimer (
      .clk      (clk),
      .reset    (reset),
      .clr      (timerClr),
      .en       (timerEn),
      .load     (1'b0),
      .loadValue('0),
      .expired  (timerExpired)
   );

   assign jump_offset   = instr[JUMP_MSB:JUMP_LSB];
   assign branch_offset = instr[IMM_MSB:IMM_LSB];
   assign dbgState      = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a queue-based scoreboard of fetched words.
module tb_instruction_fetch_unit;

   localparam int PC_W = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            stall;
   logic            new_pc_valid;
   logic [31:0]     new_pc;
   logic            instr_valid;
   logic [31:0]     instr;
   logic [PC_W-1:0] old_pc;
   logic [25:0]     jump_offset;
   logic [15:0]     branch_offset;
   logic            fetch_fault;
   logic [1:0]      dbgState;

   int checks = 0;
   int errors = 0;

   logic [31:0]     exp_q[$];
   logic [PC_W-1:0] pc_q[$];

   instruction_fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .new_pc_valid (new_pc_valid),
      .new_pc       (new_pc),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .old_pc       (old_pc),
      .jump_offset  (jump_offset),
      .branch_offset(branch_offset),
      .fetch_fault  (fetch_fault),
      .dbgState     (dbgState)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset        = 1'b1;
      imem_ack     = 1'b0;
      imem_rdata   = 32'h0;
      new_pc_valid = 1'b0;
      new_pc       = 32'h0;
      stall        = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic waitReq(input string tag);
      int n = 0;
      while (!imem_req && n < 20) begin
         step();
         n++;
      end
      check({tag, " req seen"}, 32'(imem_req), 32'd1);
   endtask

   // Memory responder: ack after 'delay' extra cycles, then score the latched word.
   task automatic serve(input logic [PC_W-1:0] addr, input logic [31:0] data, input int delay);
      logic [31:0]     expInstr;
      logic [PC_W-1:0] expPc;
      waitReq("serve");
      check("fetch addr", 32'(imem_addr), 32'(addr));
      for (int d = 0; d < delay; d++) begin
         step();
         check("req held", 32'(imem_req), 32'd1);
         check("addr held", 32'(imem_addr), 32'(addr));
         check("no early valid", 32'(instr_valid), 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      exp_q.push_back(data);
      pc_q.push_back(addr);
      step();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      check("req drop", 32'(imem_req), 32'd0);
      check("instr valid", 32'(instr_valid), 32'd1);
      if (exp_q.size() > 0) begin
         expInstr = exp_q.pop_front();
         expPc    = pc_q.pop_front();
         check("instr", instr, expInstr);
         check("old pc", 32'(old_pc), 32'(expPc));
         check("jump offset", 32'(jump_offset), {6'b0, expInstr[25:0]});
         check("branch offset", 32'(branch_offset), {16'b0, expInstr[15:0]});
      end
   endtask

   task automatic issuePc(input logic [31:0] npc);
      new_pc_valid = 1'b1;
      new_pc       = npc;
      step();
      new_pc_valid = 1'b0;
      new_pc       = $urandom;
      check("valid clears on accept", 32'(instr_valid), 32'd0);
   endtask

   initial begin
      int n;
      doReset();
      check("reset req", 32'(imem_req), 32'd0);
      check("reset valid", 32'(instr_valid), 32'd0);
      check("reset instr", instr, 32'h0);
      check("reset fault", 32'(fetch_fault), 32'd0);
      check("reset state", 32'(dbgState), 32'd0);

      // Zero-wait fetch from reset PC
      serve(16'h0000, 32'h0800_0010, 0);
      check("first jump", 32'(jump_offset), 32'h10);

      // Delayed ack
      issuePc(32'h0000_0004);
      serve(16'h0004, 32'h1234_5678, 5);

      // Stall blocks PC update
      stall        = 1'b1;
      new_pc_valid = 1'b1;
      new_pc       = 32'h0000_0040;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall valid held", 32'(instr_valid), 32'd1);
         check("stall no req", 32'(imem_req), 32'd0);
         check("stall old pc", 32'(old_pc), 32'h0004);
         check("stall instr", instr, 32'h1234_5678);
      end
      stall = 1'b0;
      step();
      new_pc_valid = 1'b0;
      check("release accept", 32'(instr_valid), 32'd0);
      serve(16'h0040, 32'hA5A5_0F0F, $urandom_range(0, 3));

      // Truncation and wrap
      issuePc(32'h0001_FFFC);
      serve(16'hFFFC, 32'h0C00_0123, 1);
      issuePc(32'h0001_0000);
      serve(16'h0000, 32'h2000_FFFF, 0);

      // Ack timeout
      issuePc(32'h0000_0100);
      waitReq("timeout");
      n = 0;
      while (imem_req && n < 40) begin
         n++;
         step();
      end
      check("timeout cycles", 32'(n), 32'd15);
      check("timeout fault", 32'(fetch_fault), 32'd1);
      imem_ack     = 1'b1;
      new_pc_valid = 1'b1;
      new_pc       = 32'h0000_0200;
      for (int i = 0; i < 3; i++) step();
      imem_ack     = 1'b0;
      new_pc_valid = 1'b0;
      check("fault sticky", 32'(fetch_fault), 32'd1);
      check("fault no req", 32'(imem_req), 32'd0);
      check("fault no valid", 32'(instr_valid), 32'd0);
      check("fault state", 32'(dbgState), 32'd3);
      doReset();
      check("fault cleared", 32'(fetch_fault), 32'd0);
      serve(16'h0000, 32'h0000_BEEF, 0);

      // Reset during WAIT with ack in the same cycle
      doReset();
      waitReq("reset in wait");
      reset      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      reset    = 1'b0;
      imem_ack = 1'b0;
      check("rst ack valid", 32'(instr_valid), 32'd0);
      check("rst ack instr", instr, 32'h0);
      check("rst ack req", 32'(imem_req), 32'd0);
      serve(16'h0000, 32'h3333_4444, 2);

      // Misaligned new_pc
`ifdef IF_ALIGN_CHECK_EN
      new_pc_valid = 1'b1;
      new_pc       = 32'h0000_0042;
      step();
      new_pc_valid = 1'b0;
      check("align fault", 32'(fetch_fault), 32'd1);
      for (int i = 0; i < 3; i++) step();
      check("align no req", 32'(imem_req), 32'd0);
`else
      issuePc(32'h0000_0042);
      serve(16'h0040, 32'h5555_6666, 0);
      check("align no fault", 32'(fetch_fault), 32'd0);
`endif

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
